// File: rtl/key_onehot_capture.sv
// Key front-end: synchronises and debounces four raw key lines, then captures a single
// key press as a registered one-hot code. The code is held under a valid/ack handshake.
module key_onehot_capture #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       ack,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       valid,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // A level change is accepted on the edge where the counter would reach DB_CYCLES,
    // so the last value the counter actually holds is DB_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       meta_q;
    logic [3:0]       sync_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       code_q;
    logic [3:0]       code_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;

    logic             stable_any;
    logic             stable_onehot;

    // Two-flop synchroniser per key line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= key_in;
            sync_q <= meta_q;
        end
    end

    // Per-bit debounce: the counter only runs while the synchronised level differs from
    // the accepted level, and any return to agreement restarts it from zero.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_any    = (stable_q != 4'b0000);
    assign stable_onehot = stable_any && ((stable_q & (stable_q - 4'd1)) == 4'b0000);

    // Capture FSM; the code register only ever loads a one-hot value or zero.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_onehot) begin
                    code_d  = stable_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (stable_any) begin
                    err_d   = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            HOLD: begin
                if (ack) begin
                    code_d  = 4'b0000;
                    valid_d = 1'b0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!stable_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                code_d  = 4'b0000;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 4'b0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign {a, b, c, d} = code_q;
    assign valid        = valid_q;
    assign err          = err_q;

endmodule
